// File: rtl/memory_stage_access_unit.sv
// memory_stage_access_unit
// Memory-stage access unit. It turns the M-stage load/store controls into a
// req/ack data-memory transaction and stalls the pipeline while that
// transaction runs. It also owns the MEM/WB pipeline register that feeds
// writeback.
//
// Optional feature: define MEM_TIMEOUT_EN to enable the BUSY watchdog. The
// watchdog aborts a transaction after TIMEOUT_CYCLES BUSY cycles without an
// ack and pulses MemErrM for one cycle. Without the macro, BUSY waits for
// mem_ack indefinitely and MemErrM is tied to 0.

module memory_stage_access_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_WIDTH      = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    // EX/MEM register outputs (M stage)
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic                  MemWriteM,
    input  logic [DATA_WIDTH-1:0] ALUOutM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [REG_WIDTH-1:0]  WriteRegM,
    // data memory port
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    // hazard unit
    output logic                  StallM,
    output logic                  MemErrM,
    // MEM/WB register
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [DATA_WIDTH-1:0] ALUOutW,
    output logic [REG_WIDTH-1:0]  WriteRegW
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                  w_access;    // the M-stage instruction touches memory
    logic                  w_start;     // launch a request this cycle
    logic                  w_ack_ok;    // normal completion this cycle
    logic                  w_abort;     // watchdog expiry without ack this cycle
    logic                  w_expired;   // watchdog at its last BUSY cycle
    logic                  w_stall;
    logic                  w_err;

    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_rdata_hold;

    logic                  r_reg_write_w;
    logic                  r_mem_to_reg_w;
    logic [DATA_WIDTH-1:0] r_read_data_w;
    logic [DATA_WIDTH-1:0] r_alu_out_w;
    logic [REG_WIDTH-1:0]  r_write_reg_w;

    // A load with the store bit also set is treated as a store.
    assign w_access = MemtoRegM | MemWriteM;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_timed_out;

    // Count BUSY cycles; restart from zero on every new request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tmo_cnt <= '0;
        end else if (w_start) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_BUSY && !w_expired) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Remember that the current DONE cycle came from an abort.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_timed_out <= 1'b0;
        end else begin
            r_timed_out <= w_abort;
        end
    end

    assign w_expired = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_err     = (r_state == S_DONE) && r_timed_out;
`else
    assign w_expired = 1'b0;
    assign w_err     = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; an ack beats a simultaneous watchdog expiry.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_access) w_state_next = S_BUSY;
            S_BUSY:  if (mem_ack || w_expired) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: transaction strobes, stall and error.
    always_comb begin
        w_start  = 1'b0;
        w_ack_ok = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            S_IDLE:  w_start  = w_access;
            S_BUSY: begin
                w_ack_ok = mem_ack;
                w_abort  = !mem_ack && w_expired;
            end
            default: ;
        endcase
        // The DONE cycle releases the stall so the MEM/WB register takes the result.
        w_stall = w_access && (r_state != S_DONE);
    end

    // Request registers: loaded on launch and held stable until completion.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_start) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= MemWriteM;
            r_mem_addr  <= ALUOutM[ADDR_WIDTH-1:0];
            r_mem_wdata <= WriteDataM;
        end else if (w_ack_ok || w_abort) begin
            r_mem_req   <= 1'b0;
        end
    end

    // Read-data holding register; a store or an aborted access returns zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rdata_hold <= '0;
        end else if (w_ack_ok) begin
            r_rdata_hold <= r_mem_we ? '0 : mem_rdata;
        end else if (w_abort) begin
            r_rdata_hold <= '0;
        end
    end

    // MEM/WB register: advance when not stalled, otherwise insert a bubble.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_reg_write_w  <= 1'b0;
            r_mem_to_reg_w <= 1'b0;
            r_read_data_w  <= '0;
            r_alu_out_w    <= '0;
            r_write_reg_w  <= '0;
        end else if (!w_stall) begin
            r_reg_write_w  <= RegWriteM;
            r_mem_to_reg_w <= MemtoRegM;
            r_read_data_w  <= (r_state == S_DONE) ? r_rdata_hold : '0;
            r_alu_out_w    <= ALUOutM;
            r_write_reg_w  <= WriteRegM;
        end else begin
            r_reg_write_w  <= 1'b0;
            r_mem_to_reg_w <= 1'b0;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign StallM    = w_stall;
    assign MemErrM   = w_err;
    assign RegWriteW = r_reg_write_w;
    assign MemtoRegW = r_mem_to_reg_w;
    assign ReadDataW = r_read_data_w;
    assign ALUOutW   = r_alu_out_w;
    assign WriteRegW = r_write_reg_w;

endmodule
